sd_modulator_nth: RTL and testbench

//  Parametrised Nth-order 1-bit sigma-delta loop filter and quantizer: cascaded stages with feed-forward/feedback gains.

---
 rtl/sd_mod_pkg.sv | 33 +++
 rtl/sd_mod_stage.sv | 62 ++++++
 rtl/sd_modulator_nth.sv | 194 +++++++++++++++++++
 tb/tb_sd_modulator_nth.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_mod_pkg.sv
// Shared constants, recovery FSM states and the saturation helper for the
// Nth-order sigma-delta modulator.
package sd_mod_pkg;

  localparam int unsigned ORDER_MAX = 8;

  localparam logic [4:0] ADDR_FF     = 5'd0;
  localparam logic [4:0] ADDR_FB     = 5'd8;
  localparam logic [4:0] ADDR_INL    = 5'd16;
  localparam logic [4:0] ADDR_SDFB   = 5'd24;
  localparam logic [4:0] ADDR_CLR    = 5'd30;
  localparam logic [4:0] ADDR_COMMIT = 5'd31;

  localparam int unsigned WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic [0:0] {RUN, RECOVER} recover_state_e;

  // Clamp x to the signed range of a w-bit value.
  function automatic wide_t sat(input wide_t x, input int unsigned w);
    wide_t maxV;
    wide_t minV;
    maxV = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    minV = -maxV - wide_t'(1);
    if (x > maxV) begin
      return maxV;
    end else if (x < minV) begin
      return minV;
    end
    return x;
  endfunction

endpackage

// File: rtl/sd_mod_stage.sv
// One loop-filter stage: input/feedback gain selection, saturating update
// (integrator or legacy resonator form), state register and output shift.
module sd_mod_stage
  import sd_mod_pkg::*;
#(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned SHIFT_W = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    advance,
  input  logic                    zero,
  input  logic                    mainIn,
  input  logic                    fbSel,
  input  logic signed [WIDTH-1:0] ffGain,
  input  logic signed [WIDTH-1:0] fbGain,
  input  logic                    mode,
  input  logic [SHIFT_W-1:0]      shift,
  input  logic signed [WIDTH-1:0] prevOut,
  output logic signed [WIDTH-1:0] stageOut,
  output logic                    clip
);

  localparam int unsigned SumW = WIDTH + 3;
  typedef logic signed [SumW-1:0] sum_t;

  function automatic sum_t satSum(input sum_t x);
    wide_t r;
    r = sat(wide_t'(x), WIDTH);
    return r[SumW-1:0];
  endfunction

  logic signed [WIDTH-1:0] stateQ;
  logic signed [WIDTH-1:0] stateD;
  sum_t ffTerm;
  sum_t fbTerm;
  sum_t u;
  sum_t sum;
  sum_t sumSat;

  always_comb begin
    // Negating the most-negative gain clamps to the positive maximum.
    ffTerm = mainIn ? sum_t'(ffGain) : satSum(-sum_t'(ffGain));
    fbTerm = fbSel ? sum_t'(fbGain) : -sum_t'(fbGain);
    u      = ffTerm - fbTerm + sum_t'(prevOut);
    sum    = mode ? (u - sum_t'(stateQ)) : (sum_t'(stateQ) + u);
    sumSat = satSum(sum);
    clip   = (sumSat != sum);
    stateD = sumSat[WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ <= '0;
    end else if (advance) begin
      stateQ <= zero ? '0 : stateD;
    end
  end

  assign stageOut = stateQ >>> shift;

endmodule

// File: rtl/sd_modulator_nth.sv
// Nth-order 1-bit sigma-delta modulator: shadowed coefficient banks with
// strobe-aligned commit, cascaded stages, quantizer and instability recovery.
module sd_modulator_nth
  import sd_mod_pkg::*;
#(
  parameter int unsigned ORDER        = 4,
  parameter int unsigned WIDTH        = 24,
  parameter int unsigned SHIFT_W      = 3,
  parameter int unsigned STABLE_LIMIT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             mainIn,
  output logic             mainOut,
  input  logic             cfgWrite,
  input  logic [4:0]       cfgAddr,
  input  logic [WIDTH-1:0] cfgData,
  output logic             cfgReady,
  output logic             overflow,
  output logic [7:0]       recoverCount
);

  localparam int unsigned SumW = WIDTH + 3;
  typedef logic signed [WIDTH-1:0] coef_t;
  typedef logic signed [SumW-1:0] sum_t;

  function automatic sum_t satSum(input sum_t x);
    wide_t r;
    r = sat(wide_t'(x), WIDTH);
    return r[SumW-1:0];
  endfunction

  coef_t            ffShadow [ORDER+1];
  coef_t            ffActive [ORDER+1];
  coef_t            fbShadow [ORDER];
  coef_t            fbActive [ORDER];
  logic [SHIFT_W:0] inlShadow[ORDER];
  logic [SHIFT_W:0] inlActive[ORDER];
  coef_t            sdfbShadow;
  coef_t            sdfbActive;
  logic             commitPending;

  coef_t            stageOut [ORDER];
  logic [ORDER-1:0] stageClip;
  coef_t            sdQ;
  coef_t            sdD;
  sum_t             ffLast;
  sum_t             vSum;
  sum_t             vSat;
  sum_t             sdfbTerm;
  sum_t             sdSum;
  sum_t             sdSat;
  logic             vClip;
  logic             sdClip;
  logic             anyClip;

  recover_state_e   stateQ;
  recover_state_e   stateD;
  logic [7:0]       satRunQ;
  logic [7:0]       satRunD;
  logic             doRecover;
  logic             cfgAccept;
  logic             ffHit;

  assign cfgReady  = ~commitPending;
  assign cfgAccept = cfgWrite & ~commitPending;
  // At ORDER=8 address 8 is ffGain[8]; the feed-forward map takes priority.
  assign ffHit     = (cfgAddr <= 5'(ORDER));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ffShadow      <= '{default: '0};
      fbShadow      <= '{default: '0};
      inlShadow     <= '{default: '0};
      sdfbShadow    <= '0;
      ffActive      <= '{default: '0};
      fbActive      <= '{default: '0};
      inlActive     <= '{default: '0};
      sdfbActive    <= '0;
      commitPending <= 1'b0;
    end else begin
      if (cfgAccept) begin
        for (int k = 0; k <= ORDER; k++) begin
          if (cfgAddr == ADDR_FF + 5'(k)) ffShadow[k] <= cfgData;
        end
        for (int k = 0; k < ORDER; k++) begin
          if (!ffHit && cfgAddr == ADDR_FB + 5'(k)) fbShadow[k] <= cfgData;
          if (cfgAddr == ADDR_INL + 5'(k)) inlShadow[k] <= cfgData[SHIFT_W:0];
        end
        if (cfgAddr == ADDR_SDFB) sdfbShadow <= cfgData;
      end
      // The committing strobe still computes with the old active bank.
      if (enable && commitPending) begin
        ffActive      <= ffShadow;
        fbActive      <= fbShadow;
        inlActive     <= inlShadow;
        sdfbActive    <= sdfbShadow;
        commitPending <= 1'b0;
      end else if (cfgAccept && cfgAddr == ADDR_COMMIT) begin
        commitPending <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < ORDER; k++) begin : genStage
    coef_t prevOut;
    if (k == 0) begin : genFirst
      assign prevOut = '0;
    end else begin : genChain
      assign prevOut = stageOut[k-1];
    end
    sd_mod_stage #(
      .WIDTH  (WIDTH),
      .SHIFT_W(SHIFT_W)
    ) uStage (
      .clock   (clock),
      .reset   (reset),
      .advance (enable),
      .zero    (doRecover),
      .mainIn  (mainIn),
      .fbSel   (mainOut),
      .ffGain  (ffActive[k]),
      .fbGain  (fbActive[k]),
      .mode    (inlActive[k][SHIFT_W]),
      .shift   (inlActive[k][SHIFT_W-1:0]),
      .prevOut (prevOut),
      .stageOut(stageOut[k]),
      .clip    (stageClip[k])
    );
  end

  always_comb begin
    ffLast   = mainIn ? sum_t'(ffActive[ORDER]) : satSum(-sum_t'(ffActive[ORDER]));
    vSum     = ffLast + sum_t'(stageOut[ORDER-1]);
    vSat     = satSum(vSum);
    vClip    = (vSat != vSum);
    sdfbTerm = mainOut ? sum_t'(sdfbActive) : -sum_t'(sdfbActive);
    sdSum    = vSat - sdfbTerm - sum_t'(sdQ);
    sdSat    = satSum(sdSum);
    sdClip   = (sdSat != sdSum);
    sdD      = sdSat[WIDTH-1:0];
    anyClip  = (|stageClip) | vClip | sdClip;
  end

  always_comb begin
    stateD    = stateQ;
    satRunD   = satRunQ;
    doRecover = 1'b0;
    if (enable) begin
      unique case (stateQ)
        RUN: begin
          satRunD = anyClip ? (satRunQ + 8'd1) : 8'd0;
          if (satRunD == 8'(STABLE_LIMIT)) stateD = RECOVER;
        end
        RECOVER: begin
          doRecover = 1'b1;
          satRunD   = 8'd0;
          stateD    = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ  <= RUN;
      satRunQ <= 8'd0;
      sdQ     <= '0;
      mainOut <= 1'b1;
    end else begin
      stateQ  <= stateD;
      satRunQ <= satRunD;
      if (enable) begin
        sdQ     <= doRecover ? '0 : sdD;
        mainOut <= doRecover ? 1'b1 : ~sdD[WIDTH-1];
      end
    end
  end

  // A recovery setting overflow outranks a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow     <= 1'b0;
      recoverCount <= 8'd0;
    end else if (doRecover) begin
      overflow <= 1'b1;
      if (recoverCount != 8'hFF) recoverCount <= recoverCount + 8'd1;
    end else if (cfgAccept && cfgAddr == ADDR_CLR) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_modulator_nth.sv
// Directed bench for sd_modulator_nth with a cycle-level reference model and
// an expected-output queue checked after every clock.
module tb_sd_modulator_nth;

  localparam int ORDER = 2;
  localparam int WIDTH = 24;
  localparam int LIMIT = 16;
  localparam longint MaxV = 64'sd8388607;
  localparam longint MinV = -64'sd8388608;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             mainIn;
  logic             mainOut;
  logic             cfgWrite;
  logic [4:0]       cfgAddr;
  logic [WIDTH-1:0] cfgData;
  logic             cfgReady;
  logic             overflow;
  logic [7:0]       recoverCount;

  sd_modulator_nth #(
    .ORDER       (ORDER),
    .WIDTH       (WIDTH),
    .SHIFT_W     (3),
    .STABLE_LIMIT(LIMIT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .mainIn      (mainIn),
    .mainOut     (mainOut),
    .cfgWrite    (cfgWrite),
    .cfgAddr     (cfgAddr),
    .cfgData     (cfgData),
    .cfgReady    (cfgReady),
    .overflow    (overflow),
    .recoverCount(recoverCount)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       q;
    logic       rdy;
    logic       ovf;
    logic [7:0] cnt;
    logic [23:0] s0;
    logic [23:0] sd;
  } obs_t;

  obs_t expQ[$];
  int   vectors;
  int   miscompares;
  int   ones;
  int   guard;

  // Reference model state
  longint     shFf[ORDER+1], acFf[ORDER+1];
  longint     shFb[ORDER], acFb[ORDER];
  logic [3:0] shInl[ORDER], acInl[ORDER];
  longint     shSdfb, acSdfb;
  longint     mS[ORDER];
  longint     mSd;
  bit         mQ, mPending, mRecover, mOverflow;
  int         mSatRun, mRecCnt;

  function automatic longint sat(input longint x);
    if (x > MaxV) return MaxV;
    if (x < MinV) return MinV;
    return x;
  endfunction

  function automatic longint gSel(input longint x, input bit s);
    return s ? x : sat(-x);
  endfunction

  task automatic modelReset();
    for (int k = 0; k <= ORDER; k++) begin shFf[k] = 0; acFf[k] = 0; end
    for (int k = 0; k < ORDER; k++) begin
      shFb[k] = 0; acFb[k] = 0; shInl[k] = 0; acInl[k] = 0; mS[k] = 0;
    end
    shSdfb = 0; acSdfb = 0; mSd = 0; mQ = 1; mPending = 0; mRecover = 0;
    mOverflow = 0; mSatRun = 0; mRecCnt = 0;
  endtask

  task automatic modelStrobe(input bit b);
    longint prev, u, sum, v, sdSum, sdN;
    longint ns[ORDER];
    bit clip;
    clip = 0;
    prev = 0;
    for (int k = 0; k < ORDER; k++) begin
      u = gSel(acFf[k], b) - (mQ ? acFb[k] : -acFb[k]) + prev;
      sum = acInl[k][3] ? (u - mS[k]) : (mS[k] + u);
      ns[k] = sat(sum);
      if (ns[k] != sum) clip = 1;
      prev = mS[k] >>> acInl[k][2:0];
    end
    v = gSel(acFf[ORDER], b) + prev;
    if (sat(v) != v) clip = 1;
    v = sat(v);
    sdSum = v - (mQ ? acSdfb : -acSdfb) - mSd;
    sdN = sat(sdSum);
    if (sdN != sdSum) clip = 1;
    if (mPending) begin
      acFf = shFf; acFb = shFb; acInl = shInl; acSdfb = shSdfb; mPending = 0;
    end
    if (mRecover) begin
      for (int k = 0; k < ORDER; k++) mS[k] = 0;
      mSd = 0; mOverflow = 1; mSatRun = 0; mRecover = 0;
      if (mRecCnt < 255) mRecCnt++;
    end else begin
      mS = ns;
      mSd = sdN;
      mSatRun = clip ? mSatRun + 1 : 0;
      if (mSatRun == LIMIT) mRecover = 1;
    end
    mQ = (mSd >= 0);
  endtask

  task automatic modelCycle(input bit en, input bit b, input bit wr, input logic [4:0] a,
                            input logic [23:0] d);
    bit acc;
    acc = wr && !mPending;
    if (acc && a == 5'd30) mOverflow = 0;
    if (en) modelStrobe(b);
    if (acc) begin
      if (a <= ORDER) shFf[a] = longint'($signed(d));
      else if (a >= 8 && a < 8 + ORDER) shFb[a-8] = longint'($signed(d));
      else if (a >= 16 && a < 16 + ORDER) shInl[a-16] = d[3:0];
      else if (a == 5'd24) shSdfb = longint'($signed(d));
      else if (a == 5'd31) mPending = 1;
    end
  endtask

  function automatic obs_t expNow();
    obs_t e;
    e.q = mQ; e.rdy = !mPending; e.ovf = mOverflow; e.cnt = mRecCnt[7:0];
    e.s0 = mS[0][23:0]; e.sd = mSd[23:0];
    return e;
  endfunction

  task automatic checkOut(input string tag);
    obs_t got, exp;
    got = {mainOut, cfgReady, overflow, recoverCount, dut.genStage[0].uStage.stateQ, dut.sdQ};
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %h with no expected entry queued", tag, got);
    end else begin
      exp = expQ.pop_front();
      assert (got === exp) else begin
        miscompares++;
        $error("FAIL %s: observed q/rdy/ovf/cnt/s0/sd=%h required %h", tag, got, exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h required %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input bit en, input bit b, input bit wr = 1'b0,
                      input logic [4:0] a = 5'd0, input logic [23:0] d = 24'd0);
    enable = en; mainIn = b; cfgWrite = wr; cfgAddr = a; cfgData = d;
    modelCycle(en, b, wr, a, d);
    expQ.push_back(expNow());
    @(posedge clock);
    #1;
    cfgWrite = 1'b0;
    checkOut(tag);
  endtask

  task automatic cfg(input string tag, input logic [4:0] a, input logic [23:0] d);
    step(tag, 1'b0, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; enable = 1'b0; mainIn = 1'b0; cfgWrite = 1'b0; cfgAddr = '0; cfgData = '0;
    modelReset();
    #12;
    expQ.push_back(expNow());
    checkOut("reset");
    @(posedge clock);
    #1 reset = 1'b0;

    // All-zero coefficients: output pinned high
    for (int i = 0; i < 20; i++) step("zeroGains", 1'b1, i[0]);
    chk("zeroOut", {31'd0, mainOut}, 32'd1);

    // First-order style loop with alternating input
    cfg("cfgFf0", 5'd0, 24'h000100);
    cfg("cfgFb0", 5'd8, 24'h000100);
    cfg("cfgSdfb", 5'd24, 24'h000100);
    cfg("cfgCommit", 5'd31, 24'd0);
    step("commitStrobe", 1'b1, 1'b1);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      step("duty", 1'b1, ~i[0]);
      ones += int'(mainOut);
    end
    chk("duty50", {31'd0, (ones >= 127 && ones <= 129)}, 32'd1);

    // Shadow write without commit, then commit timing and dropped write
    cfg("shadowFf0", 5'd0, 24'h001000);
    cfg("unmapped", 5'd5, 24'h123456);
    for (int i = 0; i < 10; i++) step("noCommit", 1'b1, ~i[0]);
    cfg("commit3", 5'd31, 24'd0);
    chk("rdyLow", {31'd0, cfgReady}, 32'd0);
    cfg("dropped", 5'd0, 24'h002000);
    chk("rdyStillLow", {31'd0, cfgReady}, 32'd0);
    step("commit3Strobe", 1'b1, 1'b1);
    chk("rdyBack", {31'd0, cfgReady}, 32'd1);
    for (int i = 0; i < 30; i++) step("newGain", 1'b1, i[0]);

    // Full chain with shifts, resonator mode, random strobes and a long hold
    cfg("cfgFf0b", 5'd0, 24'h004000);
    cfg("cfgFb0b", 5'd8, 24'h003000);
    cfg("cfgFf1", 5'd1, 24'h001000);
    cfg("cfgFb1", 5'd9, 24'h002000);
    cfg("cfgFf2", 5'd2, 24'hFFF800);
    cfg("cfgSdfbb", 5'd24, 24'h010000);
    cfg("cfgInl0", 5'd16, 24'h000001);
    cfg("cfgInl1", 5'd17, 24'h00000A);
    cfg("commit5", 5'd31, 24'd0);
    for (int i = 0; i < 120; i++) begin
      if (i == 60) begin
        for (int j = 0; j < 100; j++) step("hold", 1'b0, 1'($urandom_range(1, 0)));
      end
      step("chain", ($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)));
    end

    // Async reset while a commit is pending
    cfg("cfgPre", 5'd0, 24'h000800);
    cfg("commitRst", 5'd31, 24'd0);
    #3 reset = 1'b1;
    #1;
    chk("rstRdy", {31'd0, cfgReady}, 32'd1);
    chk("rstQ", {31'd0, mainOut}, 32'd1);
    chk("rstS0", dut.genStage[0].uStage.stateQ, 32'd0);
    modelReset();
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) step("postRst", 1'b1, 1'($urandom_range(1, 0)));

    // Saturation and recovery
    cfg("cfgMax", 5'd0, 24'h7FFFFF);
    cfg("commit4", 5'd31, 24'd0);
    step("commit4Strobe", 1'b1, 1'b1);
    step("satFirst", 1'b1, 1'b1);
    chk("s0Pinned", dut.genStage[0].uStage.stateQ, 32'h007FFFFF);
    for (int i = 0; i < 16; i++) step("satRun", 1'b1, 1'b1);
    chk("s0NoWrap", dut.genStage[0].uStage.stateQ, 32'h007FFFFF);
    chk("ovfBefore", {31'd0, overflow}, 32'd0);
    step("recover", 1'b1, 1'b1);
    chk("recS0", dut.genStage[0].uStage.stateQ, 32'd0);
    chk("recSd", dut.sdQ, 32'd0);
    chk("recOvf", {31'd0, overflow}, 32'd1);
    chk("recCnt", {24'd0, recoverCount}, 32'd1);

    // Clear racing a recovery: set wins; a later clear takes effect
    cfg("clr1", 5'd30, 24'd0);
    chk("clrOvf", {31'd0, overflow}, 32'd0);
    guard = 0;
    while (!mRecover && guard < 64) begin
      step("toRecover", 1'b1, 1'b1);
      guard++;
    end
    chk("recoverReached", {31'd0, mRecover}, 32'd1);
    step("clrRace", 1'b1, 1'b1, 1'b1, 5'd30, 24'd0);
    chk("raceOvf", {31'd0, overflow}, 32'd1);
    chk("raceCnt", {24'd0, recoverCount}, 32'd2);
    cfg("clr2", 5'd30, 24'd0);
    chk("laterClr", {31'd0, overflow}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
